// File: rtl/md_pkg.sv
// Shared encodings and sizes for the iterative multiply/divide unit.
package md_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN_FIX,
        S_DONE
    } md_state_e;

endpackage

// File: rtl/md_abs_32.sv
// Conditional two's-complement negate, used for magnitudes and sign fix-up.
module md_abs_32 (
    input  logic        i_neg,
    input  logic [31:0] i_val,
    output logic [31:0] o_val
);

    assign o_val = i_neg ? (~i_val + 32'd1) : i_val;

endmodule

// File: rtl/md_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
module md_unit #(
    parameter int WIDTH = md_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import md_pkg::*;

    md_state_e r_state;
    md_state_e w_next;

    logic [4:0]       r_cnt;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_fit;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH-1:0] w_neg_hi;
    logic [WIDTH-1:0] w_neg_lo;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_cnt == 5'(STEPS - 1));

    md_abs_32 u_abs_a (
        .i_neg (op[0] & operand_a[WIDTH-1]),
        .i_val (operand_a),
        .o_val (w_abs_a)
    );

    md_abs_32 u_abs_b (
        .i_neg (op[0] & operand_b[WIDTH-1]),
        .i_val (operand_b),
        .o_val (w_abs_b)
    );

    // Multiply: {acc_hi,acc_lo} shifts right; divide: remainder in acc_hi, quotient into acc_lo.
    assign w_madd    = r_acc_lo[0] ? ({1'b0, r_acc_hi} + {1'b0, r_opnd})
                                   : {1'b0, r_acc_hi};
    assign w_rem_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};
    assign w_fit     = ~w_diff[WIDTH];
    assign w_step_hi = r_div ? (w_fit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0])
                             : w_madd[WIDTH:1];
    assign w_step_lo = r_div ? {r_acc_lo[WIDTH-2:0], w_fit}
                             : {w_madd[0], r_acc_lo[WIDTH-1:1]};

    md_abs_32 u_fix_hi (
        .i_neg (r_div ? r_neg_r : r_neg_q),
        .i_val (r_acc_hi),
        .o_val (w_neg_hi)
    );

    md_abs_32 u_fix_lo (
        .i_neg (r_neg_q),
        .i_val (r_acc_lo),
        .o_val (w_neg_lo)
    );

    // 64-bit negate: the +1 only carries into the high word when the low word is zero.
    assign w_res_hi = (!r_div && r_neg_q && r_acc_lo != '0) ? ~r_acc_hi : w_neg_hi;
    assign w_res_lo = r_dbz ? '1 : w_neg_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (start) w_next = S_CALC;
            S_CALC:     if (w_last) w_next = S_SIGN_FIX;
            S_SIGN_FIX: w_next = S_DONE;
            S_DONE:     w_next = start ? S_CALC : S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if (w_accept) begin
                r_cnt    <= '0;
                r_div    <= op[1];
                r_neg_q  <= op[0] & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                r_neg_r  <= op[0] & operand_a[WIDTH-1];
                r_dbz    <= op[1] && (operand_b == '0);
                r_acc_hi <= '0;
                r_acc_lo <= op[1] ? w_abs_a : w_abs_b;
                r_opnd   <= op[1] ? w_abs_b : w_abs_a;
            end else if (r_state == S_CALC) begin
                r_cnt    <= r_cnt + 5'd1;
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
            end
            if (r_state == S_SIGN_FIX) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign busy        = (r_state == S_CALC) || (r_state == S_SIGN_FIX);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = (r_state == S_DONE) && r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit against a 64-bit arithmetic reference.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk = 0;
    int n_err = 0;

    md_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int     ia;
        int     ib;
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        ia = a;
        ib = b;
        sa = o[0] ? longint'(ia) : longint'({32'h0, a});
        sb = o[0] ? longint'(ib) : longint'({32'h0, b});
        if (!o[1]) begin
            p = sa * sb;
            return {1'b0, p};
        end
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit now, input int inj);
        logic [64:0] e;
        int n;
        e = model(o, a, b);
        if (!now) @(negedge clk);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op = 2'($urandom);
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".dbz_lo"}, 64'(div_by_zero), 64'd0);
        while (!done && n < 60) begin
            start = (n == inj);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ".lat"}, 64'(n), 64'd34);
        chk({tag, ".hi"}, 64'(hi), 64'(e[63:32]));
        chk({tag, ".lo"}, 64'(lo), 64'(e[31:0]));
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(e[64]));
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        bit seen;

        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dbz", 64'(div_by_zero), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);

        run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        run("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, -1);
        run("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, -1);
        run("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run("divu_z", 2'b10, 32'h0000_0064, 32'h0, 1'b0, -1);
        run("div_z", 2'b11, 32'h8000_0005, 32'h0, 1'b0, -1);
        run("busy_ign", 2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1'b0, 5);
        run("b2b_a", 2'b10, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0, -1);
        run("b2b_b", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, -1);
        run("b2b_c", 2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 1'b1, -1);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = 32'($urandom);
            endcase
            run("rand", ro, ra, rb, ($urandom_range(0, 3) == 0), -1);
        end

        run("pre_abort", 2'b00, 32'h0001_0003, 32'h0002_0005, 1'b0, -1);
        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        operand_a = 32'h1234_5678;
        operand_b = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.hi", 64'(hi), 64'd0);
        chk("abort.lo", 64'(lo), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("abort.quiet", 64'(seen), 64'd0);

        run("post_abort", 2'b10, 32'h1234_5678, 32'h0000_0010, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request pulse; sampled on the clk edge.
REQ-005 Port: op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Port: operand_a  input  32  multiplicand or dividend (rs).
REQ-007 Port: operand_b  input  32  multiplier or divisor (rt).
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; hi/lo hold the new result.
REQ-010 Port: div_by_zero  output  1  high with done when a DIV/DIVU divisor was 0.
REQ-011 Port: hi  output  32  HI register; product[63:32] or remainder; feeds the 32-bit result mux.
REQ-012 Port: lo  output  32  LO register; product[31:0] or quotient; feeds the 32-bit result mux.

Function
REQ-013 The FSM SHALL have four states, IDLE, CALC, SIGN_FIX and DONE, with busy=1 only in CALC and SIGN_FIX and done=1 only in DONE.
REQ-014 The unit SHALL accept start=1 only in IDLE or DONE, capturing op, |operand_a| and |operand_b| (magnitudes for signed ops, raw values for unsigned ops) and the result sign, and SHALL then enter CALC with a 5-bit counter set to 0.
REQ-015 The unit SHALL ignore start while busy=1, and SHALL leave captured operands unaffected by operand changes after acceptance.
REQ-016 CALC SHALL perform one radix-2 step per cycle, shift-add for multiply and restoring subtract-shift for divide, and SHALL move to SIGN_FIX after exactly 32 steps.
REQ-017 SIGN_FIX SHALL negate results where required and SHALL load hi/lo in the same cycle that it enters DONE.
REQ-018 If start is accepted at edge k, done SHALL be high in the cycle following edge k+33, and DONE SHALL return to IDLE on the next edge unless a new start is accepted.
REQ-019 MULT SHALL produce the 64-bit two's-complement product, and MULTU SHALL produce the unsigned product.
REQ-020 DIV quotient SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 without error.
REQ-022 For a divisor of 0, the unit SHALL keep the normal latency, set hi=operand_a and lo=0xFFFFFFFF, and assert div_by_zero together with done.
REQ-023 Outside DONE, div_by_zero SHALL be 0.
REQ-024 hi and lo SHALL hold their value until the next DONE entry.

Reset
REQ-025 While reset=1 on an edge, the unit SHALL set the state to IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and the counter and operand registers to 0.
REQ-026 Reset SHALL take priority over start.
REQ-027 Reset in CALC or SIGN_FIX SHALL abort the operation with no done pulse and no hi/lo update.

Structure
REQ-028 The package md_pkg SHALL hold the op encodings, the FSM state type, WIDTH and the step count (32).
REQ-029 One sub-module, md_abs_32, SHALL provide the conditional two's-complement negate and SHALL be used for operand magnitude and result sign fix-up.

Verification
REQ-030 MULTU with 0xFFFFFFFF x 0xFFFFFFFF SHALL give hi=0xFFFFFFFE, lo=0x00000001, with done exactly 34 cycles after start.
REQ-031 MULT with 0xFFFFFFFD x 0x00000007 SHALL give hi=0xFFFFFFFF and lo=0xFFFFFFEB.
REQ-032 DIV with 0xFFFFFFF9 / 0x00000002 SHALL give lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIV with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-033 DIVU with 0x00000064 / 0 SHALL give div_by_zero=1 with done, hi=0x00000064 and lo=0xFFFFFFFF.
REQ-034 A second start pulsed at cycle 5 of a busy operation SHALL be ignored, leaving the first result unchanged.
REQ-035 A start issued in the DONE cycle SHALL be accepted, with back-to-back results each 34 cycles apart.
REQ-036 Reset asserted at cycle 10 of DIVU 0x12345678 / 0x10 SHALL give busy=0 next cycle, no done, and hi=lo=0.
